// File: rtl/multimode_ff_bank_pkg.sv
// Shared types and constants for the multimode flip-flop bank.
package multimode_ff_bank_pkg;

    localparam int unsigned FF_MODE_W = 2;

    typedef enum logic [FF_MODE_W-1:0] {
        FF_D  = 2'b00,
        FF_T  = 2'b01,
        FF_JK = 2'b10,
        FF_SR = 2'b11
    } ff_mode_e;

endpackage

// File: rtl/ff_bank_cell.sv
// One bit of the bank: combinational next state and SR-conflict flag for the current mode.
module ff_bank_cell
    import multimode_ff_bank_pkg::*;
(
    input  logic [FF_MODE_W-1:0] mode,
    input  logic                 q,
    input  logic                 a,
    input  logic                 b,
    output logic                 q_next_c,
    output logic                 conflict_c
);

    always_comb begin
        q_next_c   = q;
        conflict_c = 1'b0;
        case (ff_mode_e'(mode))
            FF_D:  q_next_c = a;
            FF_T:  q_next_c = q ^ a;
            FF_JK: q_next_c = (a & ~q) | (~b & q);
            FF_SR: begin
                case ({a, b})
                    2'b10:   q_next_c = 1'b1;
                    2'b01:   q_next_c = 1'b0;
                    // S=R=1 holds the bit and is reported instead
                    2'b11:   conflict_c = 1'b1;
                    default: q_next_c = q;
                endcase
            end
            default: q_next_c = q;
        endcase
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit bank of run-time selectable D/T/JK/SR flip-flops with SR-conflict reporting.
// Define MULTIMODE_FF_BANK_ILL_CNT_EN to add the saturating conflict counter (ILL_CNT, CNT_CLR).
module multimode_ff_bank
    import multimode_ff_bank_pkg::*;
#(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    ,
    parameter int unsigned          CNT_W   = 8
`endif
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [FF_MODE_W-1:0]    MODE,
    input  logic [WIDTH-1:0]        A,
    input  logic [WIDTH-1:0]        B,
    output logic [WIDTH-1:0]        Q,
    output logic [WIDTH-1:0]        Q_bar,
    output logic                    ILLEGAL,
    output logic [WIDTH-1:0]        ILL_MASK
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    ,
    output logic [CNT_W-1:0]        ILL_CNT,
    input  logic                    CNT_CLR
`endif
);

    logic [WIDTH-1:0] q_next_c;
    logic [WIDTH-1:0] conflict_c;
    logic [WIDTH-1:0] mask_next_c;
    logic             illegal_next_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_bank_cell u_cell (
            .mode       (MODE),
            .q          (Q[i]),
            .a          (A[i]),
            .b          (B[i]),
            .q_next_c   (q_next_c[i]),
            .conflict_c (conflict_c[i])
        );
    end

    // Conflicts only count on enabled edges; a disabled edge clears the report.
    assign mask_next_c    = EN ? conflict_c : '0;
    assign illegal_next_c = |mask_next_c;

    // State and conflict-report registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q        <= RST_VAL;
            Q_bar    <= ~RST_VAL;
            ILL_MASK <= '0;
            ILLEGAL  <= 1'b0;
        end else begin
            if (EN) begin
                Q     <= q_next_c;
                Q_bar <= ~q_next_c;
            end
            ILL_MASK <= mask_next_c;
            ILLEGAL  <= illegal_next_c;
        end
    end

`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating count of conflict edges; clear wins over increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ILL_CNT <= '0;
        end else if (CNT_CLR) begin
            ILL_CNT <= '0;
        end else if (illegal_next_c && (ILL_CNT != CNT_MAX)) begin
            ILL_CNT <= ILL_CNT + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed self-checking bench for multimode_ff_bank (counter scenario runs when
// MULTIMODE_FF_BANK_ILL_CNT_EN is defined).
module tb_multimode_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       illegal;
    logic [7:0] ill_mask;
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    logic [1:0] ill_cnt;
    logic       cnt_clr;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_D  = 2'b00;
    localparam logic [1:0] M_T  = 2'b01;
    localparam logic [1:0] M_JK = 2'b10;
    localparam logic [1:0] M_SR = 2'b11;

`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    multimode_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) dut (
`else
    multimode_ff_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut (
`endif
        .CLK      (clk),
        .RST      (rst),
        .EN       (en),
        .MODE     (mode),
        .A        (a),
        .B        (b),
        .Q        (q),
        .Q_bar    (q_bar),
        .ILLEGAL  (illegal),
        .ILL_MASK (ill_mask)
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
        ,
        .ILL_CNT  (ill_cnt),
        .CNT_CLR  (cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] va, input logic [7:0] vb);
        rst  = r;
        en   = e;
        mode = m;
        a    = va;
        b    = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, M_D, 8'hFF, 8'h00);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want %h", q, 8'h00); end
        checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h want %h", q_bar, 8'hFF); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
        checks++; if (ill_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", ill_mask); end
    endtask

    task automatic test_d_then_t();
        step(1'b0, 1'b1, M_D, 8'hA5, 8'h00);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL d_load got %h want A5", q); end
        step(1'b0, 1'b1, M_T, 8'h0F, 8'h00);
        checks++; if (q !== 8'hAA) begin errors++; $display("FAIL t_edge1 got %h want AA", q); end
        checks++; if (q_bar !== 8'h55) begin errors++; $display("FAIL t_edge1_qbar got %h want 55", q_bar); end
        step(1'b0, 1'b1, M_T, 8'h0F, 8'h00);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL t_edge2 got %h want A5", q); end
    endtask

    task automatic test_jk();
        step(1'b0, 1'b1, M_D, 8'h0F, 8'h00);
        step(1'b0, 1'b1, M_JK, 8'hF0, 8'h3C);
        checks++; if (q !== 8'hF3) begin errors++; $display("FAIL jk_q got %h want F3", q); end
        checks++; if (q_bar !== 8'h0C) begin errors++; $display("FAIL jk_qbar got %h want 0C", q_bar); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL jk_illegal got %b want 0", illegal); end
    endtask

    task automatic test_sr_conflict();
        step(1'b0, 1'b1, M_D, 8'h00, 8'h00);
        step(1'b0, 1'b1, M_SR, 8'h81, 8'h03);
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL sr_q got %h want 80", q); end
        checks++; if (ill_mask !== 8'h01) begin errors++; $display("FAIL sr_mask got %h want 01", ill_mask); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL sr_illegal got %b want 1", illegal); end
        step(1'b0, 1'b1, M_SR, 8'h00, 8'h00);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL sr_pulse got %b want 0", illegal); end
        checks++; if (ill_mask !== 8'h00) begin errors++; $display("FAIL sr_mask_clr got %h want 00", ill_mask); end
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL sr_hold got %h want 80", q); end
    endtask

    task automatic test_enable_hold();
        // Conflict edge first so the disabled edge has a report to clear.
        step(1'b0, 1'b1, M_SR, 8'h10, 8'h10);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL en_pre_illegal got %b want 1", illegal); end
        step(1'b0, 1'b0, M_SR, 8'hFF, 8'hFF);
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL en_hold_q got %h want 80", q); end
        checks++; if (q_bar !== 8'h7F) begin errors++; $display("FAIL en_hold_qbar got %h want 7F", q_bar); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL en_illegal got %b want 0", illegal); end
        checks++; if (ill_mask !== 8'h00) begin errors++; $display("FAIL en_mask got %h want 00", ill_mask); end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, M_D, 8'h3C, 8'h00);
        step(1'b0, 1'b1, M_T, 8'hFF, 8'h00);
        checks++; if (q !== 8'hC3) begin errors++; $display("FAIL mid_t got %h want C3", q); end
        step(1'b1, 1'b0, M_SR, 8'hFF, 8'hFF);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q got %h want 00", q); end
        checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL mid_rst_qbar got %h want FF", q_bar); end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, M_D, 8'h55, 8'h00);
        checks++; if (q !== 8'h55) begin errors++; $display("FAIL b2b_d got %h want 55", q); end
        step(1'b0, 1'b1, M_T, 8'hFF, 8'h00);
        checks++; if (q !== 8'hAA) begin errors++; $display("FAIL b2b_t got %h want AA", q); end
        step(1'b0, 1'b1, M_SR, 8'h0F, 8'hF0);
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL b2b_sr got %h want 0F", q); end
        step(1'b0, 1'b1, M_JK, 8'hFF, 8'hFF);
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL b2b_jk got %h want F0", q); end
        checks++; if (q_bar !== 8'h0F) begin errors++; $display("FAIL b2b_jk_qbar got %h want 0F", q_bar); end
        // B ignored in D mode
        step(1'b0, 1'b1, M_D, 8'h3A, 8'hFF);
        checks++; if (q !== 8'h3A) begin errors++; $display("FAIL b2b_d_ignb got %h want 3A", q); end
    endtask

`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
    task automatic test_counter();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        cnt_clr = 1'b0;
        step(1'b1, 1'b0, M_D, 8'h00, 8'h00);
        checks++; if (ill_cnt !== 2'd0) begin errors++; $display("FAIL cnt_reset got %0d want 0", ill_cnt); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, M_SR, 8'hFF, 8'hFF);
            checks++;
            if (ill_cnt !== exp_cnt[i]) begin
                errors++; $display("FAIL cnt_edge%0d got %0d want %0d", i, ill_cnt, exp_cnt[i]);
            end
        end
        cnt_clr = 1'b1;
        step(1'b0, 1'b1, M_SR, 8'h01, 8'h01);
        checks++; if (ill_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", ill_cnt); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL cnt_clr_illegal got %b want 1", illegal); end
        cnt_clr = 1'b0;
        step(1'b0, 1'b1, M_SR, 8'hFF, 8'hFF);
        checks++; if (ill_cnt !== 2'd1) begin errors++; $display("FAIL cnt_multibit got %0d want 1", ill_cnt); end
        step(1'b0, 1'b0, M_SR, 8'hFF, 8'hFF);
        checks++; if (ill_cnt !== 2'd1) begin errors++; $display("FAIL cnt_hold got %0d want 1", ill_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = M_D; a = 8'h00; b = 8'h00;
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
        cnt_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_d_then_t();
        test_jk();
        test_sr_conflict();
        test_enable_hold();
        test_mid_reset();
        test_back_to_back();
`ifdef MULTIMODE_FF_BANK_ILL_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
